ring_line_responder: RTL and testbench
======================================

Name: ring_line_responder

Overview:
- Responder end of the core's line-fetch ring interface (ring_req / ring_addr / ring_ready / ring_rdata).
- Accepts one line request at a time and aligns the address down to a 64-byte line.
- Fetches LINE_WORDS words from a single-word backing-memory read port, assembles them in a line buffer, then presents the full line with ring_ready.
- Sits at the ring stop between core L1 refill logic and the shared memory / L2 side.

Parameters:
- DATA_W, 64, word width in bits.
- ADDR_W, 64, byte address width.
- LINE_WORDS, 8, words per line; must be a power of 2. Line bytes = LINE_WORDS*DATA_W/8 = 64.
- TIMEOUT_CYCLES, 256, per-word wait limit; used only with RING_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ring_req  in  1  core line request; held high from issue until the core has consumed the line.
- ring_addr  in  ADDR_W  requested byte address; stable while ring_req is high.
- ring_ready  out  1  line valid; held until ring_req falls.
- ring_rdata  out  LINE_WORDS x DATA_W  unpacked line array [0:LINE_WORDS-1]; word i is at line base + 8*i.
- ring_err  out  1  line was completed with a timed-out word. Tied 0 without the macro.
- mem_rd_en  out  1  backing read request, level-held until mem_rd_done.
- mem_addr  out  ADDR_W  backing byte address, 8-byte aligned.
- mem_rd_data  in  DATA_W  read data, valid with mem_rd_done.
- mem_rd_done  in  1  one-cycle read-complete pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; ring_ready=0; ring_err=0; mem_rd_en=0; mem_addr=0; all ring_rdata words=0; word index=0; busy=0. A reset mid-fetch abandons the fetch. Any mem_rd_done arriving after reset is ignored.
- IDLE, ring_req=1: latch base = ring_addr with the low log2(64) bits cleared; index=0; go to READ.
- READ: mem_rd_en=1, mem_addr = base + 8*index.
  - On mem_rd_done: ring_rdata[index] <= mem_rd_data.
  - If index == LINE_WORDS-1: mem_rd_en=0, go to RESP. Otherwise index+1 and mem_addr advances in the same edge; mem_rd_en stays high.
  - mem_rd_done while mem_rd_en=0 is ignored.
- RESP, ring_req=1: ring_ready=1. ring_rdata and ring_err are held stable; the core reads words over any number of cycles.
- RESP, ring_req=0: ring_ready=0 on the next edge; go to IDLE. A new request is accepted no earlier than the cycle after that.
- Latency: ring_ready rises the edge after the final mem_rd_done. With a 1-cycle memory (done the cycle after rd_en is seen), request to ready = 1 + 8 + 1 = 10 edges.
- ring_req dropped during READ: the current word read completes, then go to IDLE with no ready and ring_rdata left stale. No partial line is ever presented.
- ring_addr changes during READ or RESP: ignored; the latched base is used.
- Address wrap: base + 8*index wraps modulo 2^ADDR_W, with no carry handling.
- Unaligned ring_addr: served from the line base. ring_rdata[0] is always the base word.
- ring_rdata is updated only in READ; words not yet refetched keep previous values.

Optional Feature:
- RING_RESP_TIMEOUT_EN defined:
  - A per-word counter runs in READ and is cleared on each mem_rd_done.
  - When it reaches TIMEOUT_CYCLES-1 without done: write 0 to that word, set a sticky error flag, advance as if done, and pulse mem_rd_en low for 1 cycle.
  - ring_err = sticky flag, visible in RESP and cleared on the transition to IDLE.
- Not defined: no counter; READ waits indefinitely; ring_err constant 0.

Decomposition:
- Package ring_pkg: state enum {IDLE, READ, RESP}; LINE_BYTES=64; LINE_WORDS=8; line-offset bit count; the line-base align function.
- One sub-module, ring_line_buf: LINE_WORDS x DATA_W register file with indexed write port and parallel read-out. Control FSM stays in ring_line_responder.

Test Plan:
- Aligned fetch: ring_req=1, ring_addr=0x1000, memory returns 0x1000+i on the cycle after each rd_en → mem_addr steps 0x1000..0x1038; ring_rdata[i]=0x1000+i; ring_ready at edge 10; ring_ready falls 1 cycle after ring_req drops.
- Unaligned: ring_addr=0x2031 → first mem_addr=0x2000; ring_rdata[0]=mem[0x2000].
- Variable memory wait (done delayed 0..5 cycles per word) → all 8 words correct; mem_rd_en never drops between words; ring_ready only after the 8th done.
- Abort: drop ring_req after 3 words → FSM completes word 4, returns to IDLE, ring_ready never asserts; next request for 0x3000 served correctly.
- Async reset asserted mid-READ at word 5 → outputs zero immediately; a stray mem_rd_done after reset is ignored; a fresh request succeeds.
- RING_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=16, memory never answers word 2 → ring_rdata[2]=0; other words correct; ring_ready=1 with ring_err=1; ring_err=0 after return to IDLE.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and line geometry for the ring line responder.
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_e;

  localparam int LINE_BYTES    = 64;
  localparam int LINE_WORDS    = 8;
  localparam int LINE_OFF_BITS = $clog2(LINE_BYTES);

  // Clears the in-line byte offset so every request is served from its line base.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/ring_line_buf.sv
// Line buffer: LINE_WORDS x DATA_W registers with one indexed write port and parallel read-out.
module ring_line_buf #(
  parameter int DATA_W     = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_idx_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic [DATA_W-1:0]             rd_line_o [0:LINE_WORDS-1]
);

  logic [DATA_W-1:0] words_q [0:LINE_WORDS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      words_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      rd_line_o[i] = words_q[i];
    end
  end

endmodule

// File: rtl/ring_line_responder.sv
// Ring-stop responder: fetches a 64-byte line word by word from a backing port and presents it whole.
// Optional per-word read timeout is enabled by defining RING_RESP_TIMEOUT_EN.
module ring_line_responder #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 64,
  parameter int LINE_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ring_req,
  input  logic [ADDR_W-1:0] ring_addr,
  output logic              ring_ready,
  output logic [DATA_W-1:0] ring_rdata [0:LINE_WORDS-1],
  output logic              ring_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_done,
  output logic              busy
);

  import ring_pkg::*;

  localparam int IDX_W         = $clog2(LINE_WORDS);
  localparam int WORD_OFF_BITS = $clog2(DATA_W / 8);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              rd_hit;
  logic              timeout;
  logic              rd_gap;
  logic              word_done;
  logic              last_word;

  assign mem_rd_en  = (state_q == READ) && !rd_gap;
  assign mem_addr   = base_q + (ADDR_W'(idx_q) << WORD_OFF_BITS);
  assign rd_hit     = mem_rd_done && mem_rd_en;
  assign word_done  = rd_hit || timeout;
  assign last_word  = (idx_q == IDX_W'(LINE_WORDS - 1));
  assign ring_ready = ready_q;
  assign ring_err   = err_q;
  assign busy       = (state_q != IDLE);

`ifdef RING_RESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             gap_q;

  assign timeout = (state_q == READ) && !gap_q && !rd_hit &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rd_gap  = gap_q;

  // A timed-out word drops mem_rd_en for one cycle so the backing side sees the request retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      gap_q <= 1'b0;
    end else begin
      gap_q <= timeout;
      if ((state_q != READ) || rd_hit || timeout || gap_q) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign rd_gap  = 1'b0;
`endif

  ring_line_buf #(
    .DATA_W    (DATA_W),
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (word_done),
    .wr_idx_i (idx_q),
    .wr_data_i(rd_hit ? mem_rd_data : '0),
    .rd_line_o(ring_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (ring_req) begin
          base_d  = ADDR_W'(line_align(64'(ring_addr)));
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        if (word_done) begin
          if (timeout) begin
            err_d = 1'b1;
          end
          // A withdrawn request still lets the in-flight word land, but no partial line is shown.
          if (!ring_req) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end else if (last_word) begin
            state_d = RESP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RESP: begin
        if (ring_req) begin
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ring_line_responder.sv
// Directed bench for ring_line_responder; define RING_RESP_TIMEOUT_EN to also cover the word timeout.
module tb_ring_line_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ring_req;
  logic [63:0] ring_addr;
  logic        ring_ready;
  logic [63:0] ring_rdata [0:7];
  logic        ring_err;
  logic        mem_rd_en;
  logic [63:0] mem_addr;
  logic [63:0] mem_rd_data;
  logic        mem_rd_done;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  // Backing-memory model state
  bit          memOn     = 1'b0;
  int          memMode   = 0;
  bit          skipOn    = 1'b0;
  logic [63:0] skipAddr  = '0;
  int          waitLeft  = 0;
  int          doneCount = 0;
  logic [63:0] addrLog [$];
  bit          dropMon   = 1'b0;
  int          enDrops   = 0;
  int          waitTable [8] = '{0, 3, 1, 5, 2, 0, 4, 1};

  ring_line_responder #(
    .DATA_W        (64),
    .ADDR_W        (64),
    .LINE_WORDS    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ring_req   (ring_req),
    .ring_addr  (ring_addr),
    .ring_ready (ring_ready),
    .ring_rdata (ring_rdata),
    .ring_err   (ring_err),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_rd_done(mem_rd_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int waitOf(input int k);
    if (memMode == 1) return (k < 8) ? waitTable[k] : 0;
    if (memMode == 2) return 2;
    return 0;
  endfunction

  // Memory content: word i of line L reads back as L + i.
  function automatic logic [63:0] memWord(input logic [63:0] a);
    return (a & ~64'h3F) + ((a & 64'h3F) >> 3);
  endfunction

  // Memory responder: decides at the falling edge, DUT captures at the next rising edge.
  initial begin
    mem_rd_done = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (memOn) begin
        mem_rd_done = 1'b0;
        if (mem_rd_en && !rst && !(skipOn && mem_addr == skipAddr)) begin
          if (waitLeft > 0) begin
            waitLeft--;
          end else begin
            mem_rd_done = 1'b1;
            mem_rd_data = memWord(mem_addr);
            addrLog.push_back(mem_addr);
            doneCount++;
            waitLeft = waitOf(doneCount);
          end
        end
      end
    end
  end

  // Counts cycles where the read request lapses before the eighth word has returned.
  initial begin
    forever begin
      @(negedge clk);
      if (dropMon && busy && !ring_ready && doneCount < 8 && !mem_rd_en) enDrops++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [63:0] addr);
    ring_req  = req;
    ring_addr = addr;
  endtask

  task automatic startFetch(input logic [63:0] addr, input int mode);
    addrLog.delete();
    memMode   = mode;
    doneCount = 0;
    waitLeft  = waitOf(0);
    applyStimulus(1'b1, addr);
  endtask

  task automatic waitReady(input int budget, output int edges);
    edges = -1;
    for (int e = 1; e <= budget; e++) begin
      @(posedge clk);
      #1;
      if (ring_ready) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic dropReq(input string tag);
    applyStimulus(1'b0, ring_addr);
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_fall"}, 64'(ring_ready), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  int  edges;
  bit  readySeen;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0);
    #12;
    checkOutput("rst_ready", 64'(ring_ready), 64'd0);
    checkOutput("rst_en", 64'(mem_rd_en), 64'd0);
    checkOutput("rst_addr", mem_addr, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(ring_err), 64'd0);
    checkOutput("rst_word0", ring_rdata[0], 64'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    memOn = 1'b1;
    @(posedge clk);
    #1;

    // Aligned fetch with a one-cycle memory
    $display("[TB] aligned fetch 0x1000");
    startFetch(64'h1000, 0);
    waitReady(40, edges);
    checkOutput("t1_latency", 64'(edges), 64'd10);
    checkOutput("t1_reads", 64'(addrLog.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t1_addr%0d", i), (i < addrLog.size()) ? addrLog[i] : 64'hX, 64'h1000 + 64'(8 * i));
      checkOutput($sformatf("t1_word%0d", i), ring_rdata[i], 64'h1000 + 64'(i));
    end
    checkOutput("t1_err", 64'(ring_err), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t1_ready_hold", 64'(ring_ready), 64'd1);
    dropReq("t1");

    // Unaligned address served from its line base
    $display("[TB] unaligned fetch 0x2031");
    startFetch(64'h2031, 0);
    waitReady(40, edges);
    checkOutput("t2_latency", 64'(edges), 64'd10);
    checkOutput("t2_first_addr", (addrLog.size() > 0) ? addrLog[0] : 64'hX, 64'h2000);
    checkOutput("t2_word0", ring_rdata[0], 64'h2000);
    checkOutput("t2_word7", ring_rdata[7], 64'h2007);
    dropReq("t2");

    // Variable memory wait, total extra wait = 16 cycles
    $display("[TB] variable-wait fetch 0x4000");
    enDrops = 0;
    dropMon = 1'b1;
    startFetch(64'h4000, 1);
    waitReady(80, edges);
    dropMon = 1'b0;
    checkOutput("t3_latency", 64'(edges), 64'd26);
    checkOutput("t3_dones_at_ready", 64'(doneCount), 64'd8);
    checkOutput("t3_en_drops", 64'(enDrops), 64'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t3_word%0d", i), ring_rdata[i], 64'h4000 + 64'(i));
    end
    dropReq("t3");

    // Abort after three words: the fourth completes, nothing is presented
    $display("[TB] abort fetch 0x5000");
    startFetch(64'h5000, 2);
    for (int c = 0; c < 60 && doneCount < 3; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t4_three_done", 64'(doneCount), 64'd3);
    applyStimulus(1'b0, 64'h5000);
    readySeen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (ring_ready) readySeen = 1'b1;
    end
    checkOutput("t4_no_ready", 64'(readySeen), 64'd0);
    checkOutput("t4_dones", 64'(doneCount), 64'd4);
    checkOutput("t4_idle", 64'(busy), 64'd0);
    checkOutput("t4_word2", ring_rdata[2], 64'h5002);
    checkOutput("t4_word3", ring_rdata[3], 64'h5003);
    checkOutput("t4_word4_stale", ring_rdata[4], 64'h4004);
    startFetch(64'h3000, 0);
    waitReady(40, edges);
    checkOutput("t4b_latency", 64'(edges), 64'd10);
    checkOutput("t4b_word0", ring_rdata[0], 64'h3000);
    checkOutput("t4b_word4", ring_rdata[4], 64'h3004);
    checkOutput("t4b_word7", ring_rdata[7], 64'h3007);
    dropReq("t4b");

    // Asynchronous reset in the middle of word 5
    $display("[TB] reset mid-fetch 0x6000");
    startFetch(64'h6000, 2);
    for (int c = 0; c < 60 && doneCount < 5; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t5_five_done", 64'(doneCount), 64'd5);
    #2;
    memOn       = 1'b0;
    mem_rd_done = 1'b0;
    rst         = 1'b1;
    #1;
    checkOutput("t5_rst_en", 64'(mem_rd_en), 64'd0);
    checkOutput("t5_rst_addr", mem_addr, 64'd0);
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_word0", ring_rdata[0], 64'd0);
    checkOutput("t5_rst_word4", ring_rdata[4], 64'd0);
    applyStimulus(1'b0, 64'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    mem_rd_done = 1'b1;
    mem_rd_data = 64'hBAD0_BAD0;
    @(posedge clk);
    #1;
    mem_rd_done = 1'b0;
    checkOutput("t5_stray_word0", ring_rdata[0], 64'd0);
    checkOutput("t5_stray_busy", 64'(busy), 64'd0);
    memOn = 1'b1;
    startFetch(64'h7000, 0);
    waitReady(40, edges);
    checkOutput("t5b_latency", 64'(edges), 64'd10);
    checkOutput("t5b_word0", ring_rdata[0], 64'h7000);
    checkOutput("t5b_word5", ring_rdata[5], 64'h7005);
    dropReq("t5b");

`ifdef RING_RESP_TIMEOUT_EN
    // Word 2 never answers: 15 extra counting cycles plus one cycle with the request dropped
    $display("[TB] timeout fetch 0x8000");
    skipOn   = 1'b1;
    skipAddr = 64'h8010;
    startFetch(64'h8000, 0);
    waitReady(80, edges);
    skipOn = 1'b0;
    checkOutput("t6_latency", 64'(edges), 64'd26);
    checkOutput("t6_word1", ring_rdata[1], 64'h8001);
    checkOutput("t6_word2_zero", ring_rdata[2], 64'd0);
    checkOutput("t6_word3", ring_rdata[3], 64'h8003);
    checkOutput("t6_word7", ring_rdata[7], 64'h8007);
    checkOutput("t6_err", 64'(ring_err), 64'd1);
    dropReq("t6");
    checkOutput("t6_err_clear", 64'(ring_err), 64'd0);
`else
    checkOutput("t6_err_tied", 64'(ring_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
